cam_request_sequencer: RTL and testbench

- Upstream command stage for the 32x32 CAM. Accepts read/write/search requests from the bench or host over a valid/ready handshake and buffers them in a small FIFO.
- Issues exactly one CAM operation at a time on the CAM's enable/index/data inputs. Samples the CAM outputs after a fixed latency and returns one response per request over a valid/ready handshake.

---
 rtl/cam_request_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_cam_request_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_request_sequencer.sv
// Request sequencer in front of the 32x32 CAM: buffers read/write/search requests and
// runs one CAM operation at a time. Optional statistics counters: define CAM_SEQ_STATS_EN.
module cam_request_sequencer #(
  parameter int DATA_W     = 32,
  parameter int INDEX_W    = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int CAM_LAT    = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [1:0]         req_op_i,
  input  logic [INDEX_W-1:0] req_index_i,
  input  logic [DATA_W-1:0]  req_data_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [1:0]         rsp_op_o,
  output logic               rsp_hit_o,
  output logic               rsp_err_o,
  output logic [INDEX_W-1:0] rsp_index_o,
  output logic [DATA_W-1:0]  rsp_data_o,
`ifdef CAM_SEQ_STATS_EN
  output logic [15:0]        stat_search_hit_o,
  output logic [15:0]        stat_search_miss_o,
  output logic [15:0]        stat_write_o,
`endif
  output logic               cam_read_enable_o,
  output logic               cam_write_enable_o,
  output logic               cam_search_enable_o,
  output logic [INDEX_W-1:0] cam_read_index_o,
  output logic [INDEX_W-1:0] cam_write_index_o,
  output logic [DATA_W-1:0]  cam_write_data_o,
  output logic [DATA_W-1:0]  cam_search_data_o,
  input  logic               cam_read_valid_i,
  input  logic               cam_search_valid_i,
  input  logic [DATA_W-1:0]  cam_read_value_i,
  input  logic [INDEX_W-1:0] cam_search_index_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 2 + INDEX_W + DATA_W;
  localparam int CNT_W = (CAM_LAT > 1) ? $clog2(CAM_LAT) : 1;
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CAM_LAT - 1);

  typedef enum logic [1:0] {
    OP_READ   = 2'b00,
    OP_WRITE  = 2'b01,
    OP_SEARCH = 2'b10,
    OP_RSV    = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Request FIFO; pointers carry one extra wrap bit to tell full from empty
  logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr_q, rd_ptr_q;
  logic               fifo_empty, fifo_full;
  logic               push, pop;
  logic [ENT_W-1:0]   head;
  op_t                head_op;
  logic [INDEX_W-1:0] head_index;
  logic [DATA_W-1:0]  head_data;

  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign req_ready_o = rst_i & ~fifo_full;
  assign push        = req_valid_i & req_ready_o;

  assign head       = fifo_mem[rd_ptr_q[PTR_W-1:0]];
  assign head_op    = op_t'(head[ENT_W-1 -: 2]);
  assign head_index = head[DATA_W +: INDEX_W];
  assign head_data  = head[DATA_W-1:0];

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {req_op_i, req_index_i, req_data_i};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Operation in flight and response registers
  state_t             state_q, state_d;
  op_t                cur_op_q;
  logic [INDEX_W-1:0] cur_index_q;
  logic [DATA_W-1:0]  cur_data_q;
  logic [CNT_W-1:0]   wait_cnt_q;
  logic               capture;

  logic [1:0]         rsp_op_q;
  logic               rsp_hit_q, rsp_err_q;
  logic [INDEX_W-1:0] rsp_index_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               rsp_hit_d, rsp_err_d;
  logic [INDEX_W-1:0] rsp_index_d;
  logic [DATA_W-1:0]  rsp_data_d;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cur_op_q == OP_RSV) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == '0) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response field values as seen when the CAM outputs are sampled
  always_comb begin
    rsp_hit_d   = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_index_d = '0;
    rsp_data_d  = '0;
    case (cur_op_q)
      OP_READ: begin
        rsp_hit_d   = cam_read_valid_i;
        rsp_index_d = cur_index_q;
        rsp_data_d  = cam_read_value_i;
      end
      OP_WRITE: begin
        rsp_hit_d   = 1'b1;
        rsp_index_d = cur_index_q;
      end
      OP_SEARCH: begin
        rsp_hit_d   = cam_search_valid_i;
        rsp_index_d = cam_search_valid_i ? cam_search_index_i : '0;
      end
      default: rsp_err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      cur_op_q    <= OP_READ;
      cur_index_q <= '0;
      cur_data_q  <= '0;
      wait_cnt_q  <= '0;
      rsp_op_q    <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_index_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        cur_op_q    <= head_op;
        cur_index_q <= head_index;
        cur_data_q  <= head_data;
      end
      if (state_q == ST_ISSUE) begin
        wait_cnt_q <= CNT_LOAD;
      end else if (state_q == ST_WAIT && wait_cnt_q != '0) begin
        wait_cnt_q <= wait_cnt_q - CNT_ONE;
      end
      if (capture) begin
        rsp_op_q    <= cur_op_q;
        rsp_hit_q   <= rsp_hit_d;
        rsp_err_q   <= rsp_err_d;
        rsp_index_q <= rsp_index_d;
        rsp_data_q  <= rsp_data_d;
      end
    end
  end

  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_op_o    = rsp_op_q;
  assign rsp_hit_o   = rsp_hit_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_index_o = rsp_index_q;
  assign rsp_data_o  = rsp_data_q;

  // CAM strobes are decoded from registered state, so they are single-cycle and one-hot
  assign cam_read_enable_o   = (state_q == ST_ISSUE) && (cur_op_q == OP_READ);
  assign cam_write_enable_o  = (state_q == ST_ISSUE) && (cur_op_q == OP_WRITE);
  assign cam_search_enable_o = (state_q == ST_ISSUE) && (cur_op_q == OP_SEARCH);
  assign cam_read_index_o    = cam_read_enable_o   ? cur_index_q : '0;
  assign cam_write_index_o   = cam_write_enable_o  ? cur_index_q : '0;
  assign cam_write_data_o    = cam_write_enable_o  ? cur_data_q  : '0;
  assign cam_search_data_o   = cam_search_enable_o ? cur_data_q  : '0;

`ifdef CAM_SEQ_STATS_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stat_search_hit_o  <= '0;
      stat_search_miss_o <= '0;
      stat_write_o       <= '0;
    end else if (capture) begin
      if (cur_op_q == OP_SEARCH && cam_search_valid_i && stat_search_hit_o != '1)
        stat_search_hit_o <= stat_search_hit_o + 16'd1;
      if (cur_op_q == OP_SEARCH && !cam_search_valid_i && stat_search_miss_o != '1)
        stat_search_miss_o <= stat_search_miss_o + 16'd1;
      if (cur_op_q == OP_WRITE && stat_write_o != '1)
        stat_write_o <= stat_write_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cam_request_sequencer.sv
// Scoreboard bench for cam_request_sequencer with a behavioural CAM stub and reference model.
module tb_cam_request_sequencer;

  localparam int DATA_W     = 32;
  localparam int INDEX_W    = 5;
  localparam int FIFO_DEPTH = 4;
  localparam int CAM_LAT    = 1;

  logic               clk = 1'b0;
  logic               rst_i = 1'b1;
  logic               req_valid_i = 1'b0;
  logic               req_ready_o;
  logic [1:0]         req_op_i = '0;
  logic [INDEX_W-1:0] req_index_i = '0;
  logic [DATA_W-1:0]  req_data_i = '0;
  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic [1:0]         rsp_op_o;
  logic               rsp_hit_o, rsp_err_o;
  logic [INDEX_W-1:0] rsp_index_o;
  logic [DATA_W-1:0]  rsp_data_o;
  logic               cam_read_enable_o, cam_write_enable_o, cam_search_enable_o;
  logic [INDEX_W-1:0] cam_read_index_o, cam_write_index_o;
  logic [DATA_W-1:0]  cam_write_data_o, cam_search_data_o;
  logic               cam_read_valid_i = 1'b0;
  logic               cam_search_valid_i = 1'b0;
  logic [DATA_W-1:0]  cam_read_value_i = '0;
  logic [INDEX_W-1:0] cam_search_index_i = '0;
`ifdef CAM_SEQ_STATS_EN
  logic [15:0]        stat_search_hit_o, stat_search_miss_o, stat_write_o;
`endif

  cam_request_sequencer #(
    .DATA_W(DATA_W), .INDEX_W(INDEX_W), .FIFO_DEPTH(FIFO_DEPTH), .CAM_LAT(CAM_LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_index_i(req_index_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_op_o(rsp_op_o),
    .rsp_hit_o(rsp_hit_o), .rsp_err_o(rsp_err_o), .rsp_index_o(rsp_index_o),
    .rsp_data_o(rsp_data_o),
`ifdef CAM_SEQ_STATS_EN
    .stat_search_hit_o(stat_search_hit_o), .stat_search_miss_o(stat_search_miss_o),
    .stat_write_o(stat_write_o),
`endif
    .cam_read_enable_o(cam_read_enable_o), .cam_write_enable_o(cam_write_enable_o),
    .cam_search_enable_o(cam_search_enable_o), .cam_read_index_o(cam_read_index_o),
    .cam_write_index_o(cam_write_index_o), .cam_write_data_o(cam_write_data_o),
    .cam_search_data_o(cam_search_data_o), .cam_read_valid_i(cam_read_valid_i),
    .cam_search_valid_i(cam_search_valid_i), .cam_read_value_i(cam_read_value_i),
    .cam_search_index_i(cam_search_index_i)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CAM stub: one-cycle latency, lowest matching index wins, misses return a junk index
  logic [DATA_W-1:0] cam_mem [32];
  logic [31:0]       cam_vld = '0;

  always @(posedge clk) begin : cam_stub
    logic             found;
    logic [INDEX_W-1:0] fi;
    if (cam_write_enable_o) begin
      cam_mem[cam_write_index_o] <= cam_write_data_o;
      cam_vld[cam_write_index_o] <= 1'b1;
    end
    if (cam_read_enable_o) begin
      cam_read_valid_i <= cam_vld[cam_read_index_o];
      cam_read_value_i <= cam_vld[cam_read_index_o] ? cam_mem[cam_read_index_o] : '0;
    end
    if (cam_search_enable_o) begin
      found = 1'b0;
      fi    = '0;
      for (int i = 31; i >= 0; i--) begin
        if (cam_vld[i] && cam_mem[i] == cam_search_data_o) begin
          found = 1'b1;
          fi    = i[INDEX_W-1:0];
        end
      end
      cam_search_valid_i <= found;
      cam_search_index_i <= found ? fi : INDEX_W'($urandom_range(1, 31));
    end
  end

  // Reference model: CAM contents as a map, applied in request order
  typedef struct {
    logic [1:0]         op;
    logic               hit;
    logic               err;
    logic [INDEX_W-1:0] idx;
    logic [DATA_W-1:0]  data;
  } rsp_t;

  typedef struct {
    logic [1:0]         op;
    logic [INDEX_W-1:0] idx;
    logic [DATA_W-1:0]  data;
  } camop_t;

  rsp_t   exp_rsp [$];
  camop_t exp_cam [$];
  logic [DATA_W-1:0] m_mem [int];
  int m_hit = 0, m_miss = 0, m_wr = 0;

  task automatic model_accept(input logic [1:0] op, input logic [INDEX_W-1:0] idx,
                              input logic [DATA_W-1:0] d);
    rsp_t   r;
    camop_t c;
    int     best;
    r = '{op: op, hit: 1'b0, err: 1'b0, idx: '0, data: '0};
    c = '{op: op, idx: '0, data: '0};
    case (op)
      2'd0: begin
        r.hit = m_mem.exists(int'(idx));
        r.idx = idx;
        r.data = r.hit ? m_mem[int'(idx)] : '0;
        c.idx = idx;
      end
      2'd1: begin
        r.hit = 1'b1;
        r.idx = idx;
        m_mem[int'(idx)] = d;
        m_wr++;
        c.idx = idx;
        c.data = d;
      end
      2'd2: begin
        best = -1;
        foreach (m_mem[k]) if (m_mem[k] == d && (best < 0 || k < best)) best = k;
        r.hit = (best >= 0);
        r.idx = (best >= 0) ? INDEX_W'(best) : '0;
        if (best >= 0) m_hit++; else m_miss++;
        c.data = d;
      end
      default: r.err = 1'b1;
    endcase
    exp_rsp.push_back(r);
    if (op != 2'd3) exp_cam.push_back(c);
  endtask

  // Response ready pattern: 0 = held low, 1 = held high, 2 = random
  int rdy_mode = 1;
  always @(posedge clk) begin
    #1;
    rsp_ready_i = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
  end
  initial rsp_ready_i = 1'b1;

  // Monitor: compares every presented response and CAM strobe against the queues
  always @(negedge clk) begin
    rsp_t   r;
    camop_t c, o;
    int     n_en;
    if (rst_i) begin
      if (rsp_valid_o && rsp_ready_i) begin
        if (exp_rsp.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got op %0d with no request outstanding", rsp_op_o);
        end else begin
          r = exp_rsp.pop_front();
          check("rsp_op", rsp_op_o, r.op);
          check("rsp_hit", rsp_hit_o, r.hit);
          check("rsp_err", rsp_err_o, r.err);
          check("rsp_index", rsp_index_o, r.idx);
          check("rsp_data", rsp_data_o, r.data);
        end
      end
      n_en = int'(cam_read_enable_o) + int'(cam_write_enable_o) + int'(cam_search_enable_o);
      check("cam_enable_onehot", (n_en <= 1), 1);
      check("cam_idle_zero", {cam_read_enable_o ? '0 : cam_read_index_o,
                              cam_write_enable_o ? '0 : cam_write_index_o,
                              cam_write_enable_o ? '0 : cam_write_data_o[15:0],
                              cam_search_enable_o ? '0 : cam_search_data_o[15:0]}, 0);
      if (n_en == 1) begin
        o.op   = cam_write_enable_o ? 2'd1 : cam_search_enable_o ? 2'd2 : 2'd0;
        o.idx  = cam_read_index_o | cam_write_index_o;
        o.data = cam_write_data_o | cam_search_data_o;
        if (exp_cam.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_cam_op: got op %0d with none expected", o.op);
        end else begin
          c = exp_cam.pop_front();
          check("cam_op", o.op, c.op);
          check("cam_index", o.idx, c.idx);
          check("cam_data", o.data, c.data);
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [INDEX_W-1:0] idx,
                      input logic [DATA_W-1:0] d);
    bit done = 0;
    @(posedge clk);
    #1;
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_index_i = idx;
    req_data_i  = d;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (req_ready_o) begin
        model_accept(op, idx, d);
        done = 1;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL req_accept_timeout: got no ready expected ready within 200 cycles");
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_rsp.size() != 0 || exp_cam.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_rsp.size() != 0 || exp_cam.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d responses outstanding expected 0", exp_rsp.size());
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [1:0]  op;
    logic [31:0] d;
    int          r;
    #1 rst_i = 1'b0;
    #2;
    check("reset_req_ready", req_ready_o, 0);
    check("reset_rsp_valid", rsp_valid_o, 0);
    check("reset_enables", {cam_read_enable_o, cam_write_enable_o, cam_search_enable_o}, 0);
    check("reset_rsp_fields", {rsp_op_o, rsp_hit_o, rsp_err_o, rsp_index_o, rsp_data_o}, 0);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b1;
    @(negedge clk);
    check("ready_after_reset", req_ready_o, 1);

    // Directed write / read / search hit / search miss
    send(2'd1, 5'd3, 32'hDEADBEEF);
    send(2'd0, 5'd3, '0);
    send(2'd2, '0, 32'hDEADBEEF);
    send(2'd2, '0, 32'h12345678);
    drain();

    // Back-pressure: one request in the FSM plus a full FIFO
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) send(2'd0, INDEX_W'(i), '0);
    @(posedge clk);
    #1;
    req_valid_i = 1'b1;
    req_op_i    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_ready_low", req_ready_o, 0);
    end
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    rdy_mode = 1;
    drain();

    // Reserved op
    send(2'd3, 5'd7, 32'h55AA55AA);
    drain();

    // Reset while the read sits in WAIT
    send(2'd0, 5'd3, '0);
    r = 0;
    while (!cam_read_enable_o && r < 20) begin
      @(negedge clk);
      r++;
    end
    check("abort_read_issued", cam_read_enable_o, 1);
    @(posedge clk);
    #1 rst_i = 1'b0;
    #1;
    check("abort_rsp_valid", rsp_valid_o, 0);
    check("abort_req_ready", req_ready_o, 0);
    check("abort_cam_outputs", {cam_read_enable_o, cam_write_enable_o, cam_search_enable_o,
                                cam_read_index_o, cam_write_index_o}, 0);
    exp_rsp.delete();
    exp_cam.delete();
    m_hit = 0;
    m_miss = 0;
    m_wr = 0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b1;
    repeat (6) @(negedge clk);
    send(2'd1, 5'd9, 32'hCAFEF00D);
    send(2'd0, 5'd9, '0);
    send(2'd1, 5'd10, 32'h0BADC0DE);
    send(2'd1, 5'd11, 32'h0BADC0DE);
    send(2'd2, '0, 32'hCAFEF00D);
    send(2'd2, '0, 32'h0BADC0DE);
    send(2'd2, '0, 32'h12345678);
    drain();
`ifdef CAM_SEQ_STATS_EN
    check("stat_search_hit", stat_search_hit_o, 2);
    check("stat_search_miss", stat_search_miss_o, 1);
    check("stat_write", stat_write_o, 3);
`endif

    // Randomised traffic with random response back-pressure
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      r  = $urandom_range(0, 9);
      op = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      d  = ($urandom_range(0, 7) == 0) ? 32'hDEADBEEF : 32'hC0DE0000 + $urandom_range(0, 5);
      send(op, INDEX_W'($urandom_range(0, 31)), d);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rdy_mode = 1;
    drain();
`ifdef CAM_SEQ_STATS_EN
    check("stat_search_hit_rand", stat_search_hit_o, m_hit);
    check("stat_search_miss_rand", stat_search_miss_o, m_miss);
    check("stat_write_rand", stat_write_o, m_wr);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
